// File: rtl/alu_pkg.sv
// Shared constants for the ALU board front end.
// Button indices map the push-buttons onto the ALU register loads.
package alu_pkg;

    localparam int N_BUTTONS_DEF  = 3;
    localparam int N_SWITCHES_DEF = 6;

    localparam int BTN_A  = 2;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 0;

endpackage

// File: rtl/button_sync_debounce_cell.sv
// One push-button channel: 2-flop synchroniser, stability counter, level.
// rise flags the edge on which the debounced level will go 0 -> 1.
module debounce_cell #(
    parameter int STABLE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] count;

    // Synchronise, then require an unbroken run of disagreeing samples to flip.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Press about to be accepted on this edge.
    always_comb begin
        rise = (sync != level) && (count == LAST) && !level;
    end

endmodule

// File: rtl/button_sync_debounce.sv
// Board input conditioning ahead of top_ALU: debounced buttons, one press
// strobe at a time, and a switch snapshot coherent with that strobe.
module button_sync_debounce
    import alu_pkg::*;
#(
    parameter int N_BUTTONS     = N_BUTTONS_DEF,
    parameter int N_SWITCHES    = N_SWITCHES_DEF,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_BUTTONS-1:0]  i_buttons,
    input  logic [N_SWITCHES-1:0] i_SWs,
    output logic [N_BUTTONS-1:0]  o_btn_level,
    output logic [N_BUTTONS-1:0]  o_btn_pulse,
    output logic [N_SWITCHES-1:0] o_sw_data
);

    logic [N_BUTTONS-1:0]  rise;
    logic [N_BUTTONS-1:0]  win;
    logic [N_SWITCHES-1:0] sw_meta;
    logic [N_SWITCHES-1:0] sw_sync;

    for (genvar k = 0; k < N_BUTTONS; k++) begin : g_btn
        debounce_cell #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_cell (
            .clock(clock),
            .reset(reset),
            .raw  (i_buttons[k]),
            .level(o_btn_level[k]),
            .rise (rise[k])
        );
    end

    // Highest simultaneous press wins; lower ones are dropped for good.
    always_comb begin
        win = '0;
        for (int k = 0; k < N_BUTTONS; k++) begin
            if (rise[k]) begin
                win    = '0;
                win[k] = 1'b1;
            end
        end
    end

    // Switch synchronisers, registered strobe and strobe-aligned snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            o_btn_pulse <= '0;
            o_sw_data   <= '0;
        end else begin
            sw_meta     <= i_SWs;
            sw_sync     <= sw_meta;
            o_btn_pulse <= win;
            if (|win) begin
                o_sw_data <= sw_sync;
            end
        end
    end

endmodule
